gpr_file_scoreboard: RTL and testbench

//  Write-back consumer of the MEM/WB stage: 32x32 MIPS general-purpose register file with a per-register

---
 rtl/gpr_file_scoreboard.sv | 135 +++++++++++++
 tb/tb_gpr_file_scoreboard.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file_scoreboard.sv
// 32x32 GPR file with write-first WB bypass and a
// per-register pending-writer scoreboard for RAW stalls.
module gpr_file_scoreboard #(
  parameter int          CNT_W   = 2,
  parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic        id_rs_use,
  input  logic        id_rt_use,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  input  logic        issue_ena,
  input  logic        issue_we,
  input  logic [4:0]  issue_waddr,
  input  logic        wb_GPR_we,
  input  logic [4:0]  wb_GPR_waddr,
  input  logic [31:0] wb_GPR_wdata,
  input  logic        flush,
  output logic        stall_req,
  output logic        sb_error
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [31:0]      regs_q [1:31];
  logic [CNT_W-1:0] cnt_q  [1:31];
  logic [CNT_W-1:0] cnt_d  [1:31];
  logic [31:0]      inc;
  logic [31:0]      dec;
  logic [31:0]      busy;
  logic             err_q;
  logic             err_d;
  logic             wb_wr;
  logic             is_wr;

  assign wb_wr = wb_GPR_we & (wb_GPR_waddr != 5'd0);
  assign is_wr = issue_ena & issue_we
               & (issue_waddr != 5'd0);

  // One-hot issue/retire strobes per register
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < 32; r++) begin
      inc[r] = is_wr & (issue_waddr == 5'(r));
      dec[r] = wb_wr & (wb_GPR_waddr == 5'(r));
    end
  end

  // Counter next-state and overflow/underflow detection
  always_comb begin
    err_d = err_q;
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = CNT_ZERO;
      end else if (inc[r] && !dec[r]) begin
        if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
        else cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec[r] && !inc[r]) begin
        if (cnt_q[r] == CNT_ZERO) err_d = 1'b1;
        else cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  // A writer retiring this cycle is served by bypass
  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) begin
      busy[r] = (cnt_q[r] > CNT_ONE)
              | ((cnt_q[r] == CNT_ONE) & ~dec[r]);
    end
  end

  // Hazard request, forced low while in reset
  always_comb begin
    stall_req = reset
              & ((id_rs_use & busy[id_rs_addr])
               | (id_rt_use & busy[id_rt_addr]));
  end

  // Read port A with write-first bypass
  always_comb begin
    id_rs_data = 32'h0;
    if (id_rs_addr != 5'd0) begin
      if (wb_GPR_we && wb_GPR_waddr == id_rs_addr)
        id_rs_data = wb_GPR_wdata;
      else
        id_rs_data = regs_q[id_rs_addr];
    end
  end

  // Read port B with write-first bypass
  always_comb begin
    id_rt_data = 32'h0;
    if (id_rt_addr != 5'd0) begin
      if (wb_GPR_we && wb_GPR_waddr == id_rt_addr)
        id_rt_data = wb_GPR_wdata;
      else
        id_rt_data = regs_q[id_rt_addr];
    end
  end

  // Register array write-back; $29 resets to the stack top
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 1; r < 32; r++)
        regs_q[r] <= (r == 29) ? SP_INIT : 32'h0;
    end else if (wb_wr) begin
      regs_q[wb_GPR_waddr] <= wb_GPR_wdata;
    end
  end

  // Pending counters and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 1; r < 32; r++)
        cnt_q[r] <= CNT_ZERO;
      err_q <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++)
        cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  assign sb_error = err_q;

endmodule

// File: tb/tb_gpr_file_scoreboard.sv
// Scoreboard bench for gpr_file_scoreboard: expected
// read/stall/error tuples queued per cycle, then compared.
module tb_gpr_file_scoreboard;

  localparam logic [31:0] SP = 32'h7FFF_EFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs_addr = '0;
  logic [4:0]  id_rt_addr = '0;
  logic        id_rs_use = 1'b0;
  logic        id_rt_use = 1'b0;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        issue_ena = 1'b0;
  logic        issue_we = 1'b0;
  logic [4:0]  issue_waddr = '0;
  logic        wb_GPR_we = 1'b0;
  logic [4:0]  wb_GPR_waddr = '0;
  logic [31:0] wb_GPR_wdata = '0;
  logic        flush = 1'b0;
  logic        stall_req;
  logic        sb_error;

  typedef struct packed {
    logic [31:0] rs;
    logic [31:0] rt;
    logic        st;
    logic        er;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  gpr_file_scoreboard #(.CNT_W(2), .SP_INIT(SP)) dut (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_use(id_rs_use), .id_rt_use(id_rt_use),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .issue_ena(issue_ena), .issue_we(issue_we),
    .issue_waddr(issue_waddr),
    .wb_GPR_we(wb_GPR_we), .wb_GPR_waddr(wb_GPR_waddr),
    .wb_GPR_wdata(wb_GPR_wdata), .flush(flush),
    .stall_req(stall_req), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  task automatic expect_o(input logic [31:0] rs,
                          input logic [31:0] rt,
                          input logic st, input logic er);
    exp_q.push_back({rs, rt, st, er});
  endtask

  task automatic capture();
    obs_q.push_back({id_rs_data, id_rt_data,
                     stall_req, sb_error});
  endtask

  task automatic cyc(input logic [4:0] rs,
                     input logic [4:0] rt,
                     input logic rsu, input logic rtu,
                     input logic ie, input logic iwe,
                     input logic [4:0] iwa,
                     input logic we, input logic [4:0] wa,
                     input logic [31:0] wd,
                     input logic fl);
    @(negedge clk);
    id_rs_addr = rs;  id_rt_addr = rt;
    id_rs_use = rsu;  id_rt_use = rtu;
    issue_ena = ie;   issue_we = iwe;
    issue_waddr = iwa;
    wb_GPR_we = we;   wb_GPR_waddr = wa;
    wb_GPR_wdata = wd;
    flush = fl;
    #1 capture();
  endtask

  task automatic test_reset();
    string nm = "reset";
    obs_t e, o;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    expect_o(SP, 32'h0, 1'b0, 1'b0);
    cyc(29, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h/%h st=%b er=%b want %h/%h st=%b er=%b",
          nm, o.rs, o.rt, o.st, o.er, e.rs, e.rt, e.st, e.er);
      end
    end
  endtask

  task automatic test_bypass();
    string nm = "bypass";
    obs_t e, o;
    expect_o(0, 0, 0, 0);
    cyc(8, 8, 1, 1, 1, 1, 8, 0, 0, 0, 0);
    expect_o(32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    cyc(8, 8, 1, 1, 0, 0, 0, 1, 8, 32'hDEADBEEF, 0);
    expect_o(32'hDEADBEEF, SP, 0, 0);
    cyc(8, 29, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h/%h st=%b er=%b want %h/%h st=%b er=%b",
          nm, o.rs, o.rt, o.st, o.er, e.rs, e.rt, e.st, e.er);
      end
    end
  endtask

  task automatic test_zero();
    string nm = "zero_reg";
    obs_t e, o;
    expect_o(0, 32'hDEADBEEF, 0, 0);
    cyc(0, 8, 1, 1, 0, 0, 0, 1, 0, 32'h12345678, 0);
    expect_o(0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h/%h st=%b er=%b want %h/%h st=%b er=%b",
          nm, o.rs, o.rt, o.st, o.er, e.rs, e.rt, e.st, e.er);
      end
    end
  endtask

  task automatic test_raw();
    string nm = "raw_stall";
    obs_t e, o;
    expect_o(0, 0, 0, 0);
    cyc(9, 0, 1, 0, 1, 1, 9, 0, 0, 0, 0);
    expect_o(0, 0, 1, 0);
    cyc(9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_o(0, 0, 0, 0);
    cyc(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_o(0, 0, 1, 0);
    cyc(0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_o(32'h99, 0, 0, 0);
    cyc(9, 0, 1, 0, 0, 0, 0, 1, 9, 32'h99, 0);
    expect_o(32'h99, 0, 0, 0);
    cyc(9, 0, 1, 0, 1, 0, 9, 0, 0, 0, 0);
    expect_o(32'h99, 0, 0, 0);
    cyc(9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h/%h st=%b er=%b want %h/%h st=%b er=%b",
          nm, o.rs, o.rt, o.st, o.er, e.rs, e.rt, e.st, e.er);
      end
    end
  endtask

  task automatic test_multi();
    string nm = "multi_writer";
    obs_t e, o;
    expect_o(0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 10, 0, 0, 0, 0);
    expect_o(0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 10, 0, 0, 0, 0);
    expect_o(0, 0, 1, 0);
    cyc(10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_o(32'hA1, 0, 1, 0);
    cyc(10, 0, 1, 0, 0, 0, 0, 1, 10, 32'hA1, 0);
    expect_o(32'hA1, 0, 1, 0);
    cyc(10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_o(32'hA2, 0, 0, 0);
    cyc(10, 0, 1, 0, 0, 0, 0, 1, 10, 32'hA2, 0);
    expect_o(32'hA2, 0, 0, 0);
    cyc(10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_o(32'hA2, 0, 0, 0);
    cyc(10, 0, 1, 0, 1, 1, 10, 0, 0, 0, 0);
    expect_o(32'hA3, 0, 0, 0);
    cyc(10, 0, 1, 0, 1, 1, 10, 1, 10, 32'hA3, 0);
    expect_o(32'hA3, 0, 1, 0);
    cyc(10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_o(32'hA4, 0, 0, 0);
    cyc(10, 0, 1, 0, 0, 0, 0, 1, 10, 32'hA4, 0);
    expect_o(32'hA4, 0, 0, 0);
    cyc(10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h/%h st=%b er=%b want %h/%h st=%b er=%b",
          nm, o.rs, o.rt, o.st, o.er, e.rs, e.rt, e.st, e.er);
      end
    end
  endtask

  task automatic test_flush();
    string nm = "flush";
    obs_t e, o;
    expect_o(0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 11, 0, 0, 0, 0);
    expect_o(0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 13, 0, 0, 0, 0);
    expect_o(0, 32'h55, 1, 0);
    cyc(11, 13, 1, 1, 0, 0, 0, 1, 13, 32'h55, 1);
    expect_o(0, 32'h55, 0, 0);
    cyc(11, 13, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_o(32'h77, 0, 0, 0);
    cyc(11, 0, 1, 0, 0, 0, 0, 1, 11, 32'h77, 0);
    expect_o(32'h77, 0, 0, 1);
    cyc(11, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_o(32'h77, 0, 0, 1);
    cyc(11, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h/%h st=%b er=%b want %h/%h st=%b er=%b",
          nm, o.rs, o.rt, o.st, o.er, e.rs, e.rt, e.st, e.er);
      end
    end
  endtask

  task automatic test_reset_mid();
    string nm = "reset_mid";
    obs_t e, o;
    expect_o(0, 0, 0, 1);
    cyc(14, 0, 1, 0, 1, 1, 14, 0, 0, 0, 0);
    expect_o(0, 32'h77, 1, 1);
    cyc(14, 11, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    expect_o(0, 0, 0, 0);
    #1 capture();
    @(negedge clk);
    reset = 1'b1;
    expect_o(0, SP, 0, 0);
    cyc(14, 29, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h/%h st=%b er=%b want %h/%h st=%b er=%b",
          nm, o.rs, o.rt, o.st, o.er, e.rs, e.rt, e.st, e.er);
      end
    end
  endtask

  task automatic test_overflow();
    string nm = "overflow";
    obs_t e, o;
    for (int i = 0; i < 3; i++) begin
      expect_o(0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 12, 0, 0, 0, 0);
    end
    expect_o(0, 0, 1, 0);
    cyc(12, 0, 1, 0, 1, 1, 12, 0, 0, 0, 0);
    expect_o(0, 0, 1, 1);
    cyc(12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_o(32'hB1, 0, 1, 1);
    cyc(12, 0, 1, 0, 0, 0, 0, 1, 12, 32'hB1, 0);
    expect_o(32'hB2, 0, 1, 1);
    cyc(12, 0, 1, 0, 0, 0, 0, 1, 12, 32'hB2, 0);
    expect_o(32'hB2, 0, 1, 1);
    cyc(12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_o(32'hB3, 0, 0, 1);
    cyc(12, 0, 1, 0, 0, 0, 0, 1, 12, 32'hB3, 0);
    expect_o(32'hB3, 0, 0, 1);
    cyc(12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %h/%h st=%b er=%b want %h/%h st=%b er=%b",
          nm, o.rs, o.rt, o.st, o.er, e.rs, e.rt, e.st, e.er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero();
    test_raw();
    test_multi();
    test_flush();
    test_reset_mid();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
